prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
Downstream consumer of the 2x2 multiplier's 4-bit product.
- Sums a fixed number of consecutive products (dot-product style) and holds the total until the next stage takes it.
- Valid/ready handshake on both the input and output sides.
- Sits between the combinational multiplier and any result sink (register file, display driver).

Parameters:
PROD_W, 4, width of incoming product (matches multiplier output).
NUM_TERMS, 4, number of products summed per result; legal range 2..255.
ACC_W, 8, accumulator/result width; must be >= PROD_W.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous clear: abort current accumulation, discard any held result.
prod_i  input  PROD_W  product from multiplier.
in_valid  input  1  prod_i is valid this cycle.
in_ready  output  1  block accepts prod_i this cycle.
acc_o  output  ACC_W  accumulated result.
out_valid  output  1  acc_o holds a complete result.
out_ready  input  1  sink accepts acc_o this cycle.
term_cnt_o  output  8  number of products accepted in the current group.
ovf_o  output  1  overflow occurred in the result group (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): state=ACCUM, acc=0, term_cnt_o=0, acc_o=0, out_valid=0, ovf_o=0, in_ready=1 after release.
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Input handshake = in_valid && in_ready at the rising edge.
- ACCUM, on input handshake:
  - acc <= acc + zero-extended prod_i.
  - term_cnt increments.
  - On the NUM_TERMS-th accepted term: acc_o <= final sum, term_cnt <= 0, go to HOLD.
  - Latency: result visible on acc_o with out_valid=1 one cycle after the last term's handshake.
- HOLD:
  - acc_o, ovf_o and out_valid stay stable until out_ready=1.
  - On the out_ready handshake: out_valid <= 0, acc <= 0, ovf <= 0, return to ACCUM.
  - in_ready returns high the cycle after the output handshake; no overlap of groups.
- in_valid low: no state change. Gaps between terms are allowed and do not affect the result.
- Arithmetic: unsigned. Sum wraps modulo 2^ACC_W unless ACC_SAT_EN is defined.
- clr=1, any state, takes effect next edge:
  - acc=0, term_cnt=0, out_valid=0, ovf_o=0, state=ACCUM.
  - acc_o retains its last value.
  - If an input handshake occurs in the same cycle, clr wins and the term is discarded.
  - If an output handshake occurs in the same cycle, clr wins and the result is dropped.
- Reset asserted mid-group or in HOLD: immediate return to reset values; the partial sum is lost.
- out_ready while not in HOLD: ignored.

Optional Feature:
ACC_SAT_EN
- Defined:
  - The addition saturates at 2^ACC_W-1.
  - ovf_o sets sticky at the first saturating add in the group and is cleared on the output handshake, clr or reset.
- Undefined:
  - Sum wraps modulo 2^ACC_W.
  - ovf_o is set sticky on carry-out of the adder, with the same clearing rules.
  - This keeps the port list identical in both builds.

Decomposition:
- Shared package mult_pkg holds:
  - PROD_W constant, shared with the multiplier.
  - Default NUM_TERMS.
  - 1-bit state enum typedef {ACCUM, HOLD}.
  - Helper function for the minimum safe ACC_W: PROD_W + clog2(NUM_TERMS).
- One natural sub-module, term_counter: mod-NUM_TERMS counter with enable, sync clear and terminal-count flag. It drives term_cnt_o and the ACCUM->HOLD transition.

Test Plan:
1. Reset, then products 9,9,9,9 back-to-back with out_ready=1 -> acc_o=36 (0x24), out_valid high exactly 1 cycle after the 4th handshake, ovf_o=0.
2. Products 1,2,3,4 with in_valid gaps of 0-3 cycles, out_ready held 0 for 5 cycles -> acc_o=10 stable, in_ready=0 throughout HOLD; out_ready=1 -> out_valid drops next cycle, in_ready=1.
3. ACC_W=5, products 9,9,9,9:
   - Without macro -> acc_o=4, ovf_o=1.
   - With ACC_SAT_EN -> acc_o=31, ovf_o=1.
4. Two terms (5,6) accepted, then clr asserted with in_valid=1 and prod_i=7 -> term discarded, term_cnt_o=0. The next four terms 1,1,1,1 -> acc_o=4.
5. rst_n pulsed low asynchronously (mid-cycle) during HOLD with acc_o=36 -> out_valid=0, acc_o=0 and term_cnt_o=0 immediately. The next group 2,2,2,2 -> acc_o=8.
6. Same edge: out_ready=1 in HOLD while in_valid=1 -> input not accepted that cycle (in_ready=0), accepted the following cycle and counted as term 1 of the new group.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: constants and types shared by the 2x2 multiplier and its product accumulator.
// No ports; provides PROD_W, NUM_TERMS_DEF, state_t {ACCUM, HOLD} and min_acc_w().
package mult_pkg;
    localparam int PROD_W        = 4;
    localparam int NUM_TERMS_DEF = 4;
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
    // Smallest accumulator width that can never overflow for n terms of prod_w bits.
    function automatic int min_acc_w(input int prod_w, input int n);
        return prod_w + $clog2(n);
    endfunction
endpackage

// File: rtl/prod_accum_term_counter.sv
// term_counter: mod-N counter of accepted terms with terminal-count flag.
// Ports: clk, rst_n (async low), clr (sync clear), en (count this edge),
//        cnt[7:0] (current count), tc (en on the last term of the group).
module term_counter #(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] cnt,
    output logic       tc
);
    assign tc = en && (cnt == 8'(N - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 8'd1;
    end
endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums NUM_TERMS consecutive products and holds the total until taken.
// Ports: clk, rst_n (async low), clr (sync abort), prod_i/in_valid/in_ready (input side),
//        acc_o/out_valid/out_ready (output side), term_cnt_o (terms in current group),
//        ovf_o (sticky overflow for the group).
// Build option: define ACC_SAT_EN to saturate the sum instead of wrapping.
module prod_accum
    import mult_pkg::*;
#(
    parameter int PROD_W    = mult_pkg::PROD_W,
    parameter int NUM_TERMS = mult_pkg::NUM_TERMS_DEF,
    parameter int ACC_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        term_cnt_o,
    output logic              ovf_o
);
    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [ACC_W:0]   sum;
    logic             in_hs, out_hs, last, carry;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    // One extra bit exposes the carry used for overflow in both builds.
    assign sum    = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_i);
    assign carry  = sum[ACC_W];
`ifdef ACC_SAT_EN
    assign acc_nx = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nx = sum[ACC_W-1:0];
`endif

    term_counter #(.N(NUM_TERMS)) u_term_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .en   (in_hs),
        .cnt  (term_cnt_o),
        .tc   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACCUM;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = clr                        ? ACCUM :
                   (state == ACCUM && last)   ? HOLD  :
                   (state == HOLD && out_ready) ? ACCUM : state;
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    // acc_o is only loaded on the last term so clr can leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            acc_o <= '0;
            ovf_o <= 1'b0;
        end else if (clr || out_hs) begin
            acc   <= '0;
            ovf_o <= 1'b0;
        end else if (in_hs) begin
            acc   <= acc_nx;
            ovf_o <= ovf_o | carry;
            if (last)
                acc_o <= acc_nx;
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: scoreboard bench for prod_accum (ACC_W=8 and ACC_W=5 instances share stimulus).
module tb_prod_accum;
    localparam int NT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] prod_i = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, ovf_o;
    logic [7:0] acc_o, term_cnt_o;
    logic       in_ready5, out_valid5, ovf5;
    logic [4:0] acc5;
    logic [7:0] term_cnt5;

    int n_cmp = 0;
    int n_fail = 0;
    int total = 0;
    int terms = 0;
    logic [8:0] q8[$];
    logic [8:0] q5[$];

    always #5 clk = ~clk;

    prod_accum #(.PROD_W(4), .NUM_TERMS(NT), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_i(prod_i), .in_valid(in_valid),
        .in_ready(in_ready), .acc_o(acc_o), .out_valid(out_valid), .out_ready(out_ready),
        .term_cnt_o(term_cnt_o), .ovf_o(ovf_o));

    prod_accum #(.PROD_W(4), .NUM_TERMS(NT), .ACC_W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_i(prod_i), .in_valid(in_valid),
        .in_ready(in_ready5), .acc_o(acc5), .out_valid(out_valid5), .out_ready(out_ready),
        .term_cnt_o(term_cnt5), .ovf_o(ovf5));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {ovf, result} from the true integer sum of a group.
    function automatic logic [8:0] expect_for(input int tot, input int w);
        int mx, res;
        mx = (1 << w) - 1;
`ifdef ACC_SAT_EN
        res = (tot > mx) ? mx : tot;
`else
        res = tot % (1 << w);
`endif
        return {(tot > mx) ? 1'b1 : 1'b0, 8'(res)};
    endfunction

    task automatic model_accept(input int p);
        total += p;
        terms++;
        if (terms == NT) begin
            q8.push_back(expect_for(total, 8));
            q5.push_back(expect_for(total, 5));
            total = 0;
            terms = 0;
        end
    endtask

    task automatic model_reset();
        total = 0;
        terms = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int p, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        prod_i = 4'(p);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            model_accept(p);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_wait_out_valid", out_valid, 1);
        repeat (d) begin
            chk("hold_in_ready_low", in_ready, 0);
            chk("hold_out_valid_high", out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_take_out_valid", out_valid, 0);
        chk("post_take_in_ready", in_ready, 1);
    endtask

    initial begin : mon8
        logic seen;
        logic [8:0] held;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (!seen) begin
                    if (q8.size() == 0) begin
                        chk("mon8_unexpected_result", 1, 0);
                        held = {ovf_o, acc_o};
                    end else begin
                        held = q8.pop_front();
                        chk("acc8", {24'd0, acc_o}, {24'd0, held[7:0]});
                        chk("ovf8", {31'd0, ovf_o}, {31'd0, held[8]});
                    end
                    seen = 1'b1;
                end else begin
                    chk("hold8_stable", {23'd0, ovf_o, acc_o}, {23'd0, held});
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin : mon5
        logic seen;
        logic [8:0] held;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (out_valid5) begin
                if (!seen) begin
                    if (q5.size() == 0) begin
                        chk("mon5_unexpected_result", 1, 0);
                        held = {ovf5, 3'd0, acc5};
                    end else begin
                        held = q5.pop_front();
                        chk("acc5", {27'd0, acc5}, {27'd0, held[4:0]});
                        chk("ovf5", {31'd0, ovf5}, {31'd0, held[8]});
                    end
                    seen = 1'b1;
                end else begin
                    chk("hold5_stable", {27'd0, acc5}, {27'd0, held[4:0]});
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        int g2[4];
        g2 = '{2, 0, 3, 1};
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_o", acc_o, 0);
        chk("rst_term_cnt", term_cnt_o, 0);
        chk("rst_ovf", ovf_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // 1: 9,9,9,9 back-to-back with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < NT; i++) begin
            if (i == NT - 1) chk("t1_no_early_valid", out_valid, 0);
            send(9, 0);
        end
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_acc", acc_o, 36);
        chk("t1_ovf", ovf_o, 0);
`ifdef ACC_SAT_EN
        chk("t3_acc5_sat", acc5, 31);
`else
        chk("t3_acc5_wrap", acc5, 4);
`endif
        chk("t3_ovf5", ovf5, 1);
        @(negedge clk);
        chk("t1_valid_one_cycle", out_valid, 0);
        out_ready = 1'b0;

        // 2: 1,2,3,4 with gaps, held for 5 cycles
        for (int i = 0; i < NT; i++) send(i + 1, g2[i]);
        drain(5);

        // 4: clr wins over a same-edge input handshake
        send(5, 0);
        send(6, 1);
        clr = 1'b1;
        in_valid = 1'b1;
        prod_i = 4'd7;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        model_reset();
        chk("t4_term_cnt_cleared", term_cnt_o, 0);
        chk("t4_ovf_cleared", ovf_o, 0);
        for (int i = 0; i < NT; i++) send(1, 0);
        drain(1);

        // 5: async reset in HOLD
        for (int i = 0; i < NT; i++) send(9, 0);
        chk("t5_in_hold", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_acc_o", acc_o, 0);
        chk("t5_rst_term_cnt", term_cnt_o, 0);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < NT; i++) send(2, 0);
        drain(1);

        // 6: output take and pending input on the same edge
        for (int i = 0; i < NT; i++) send(i + 5, 0);
        chk("t6_in_hold", out_valid, 1);
        out_ready = 1'b1;
        in_valid = 1'b1;
        prod_i = 4'd3;
        chk("t6_in_ready_low", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t6_out_valid_dropped", out_valid, 0);
        chk("t6_not_accepted", term_cnt_o, 0);
        chk("t6_in_ready_back", in_ready, 1);
        @(posedge clk);
        model_accept(3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_first_term", term_cnt_o, 1);
        for (int i = 1; i < NT; i++) send(i, 0);
        drain(0);

        // random groups
        for (int g = 0; g < 20; g++) begin
            for (int i = 0; i < NT; i++) send($urandom_range(0, 15), $urandom_range(0, 3));
            drain($urandom_range(0, 4));
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
